register_file_write_controller: RTL and testbench
=================================================

Name: register_file_write_controller

Overview:
- Owns the single write port of the 16 x 32 register file: port_c, decoder_control and load_enable.
- Arbitrates that port round-robin between two writeback requesters: requester 0 is the ALU, requester 1 is the load unit.
- Keeps a 16-bit scoreboard of registers with a pending write, so decode can detect read-after-write hazards on the a_select and b_select read ports.

Parameters:
- DATA_WIDTH, 32, width of writeback data and of port_c.
- ADDR_WIDTH, 4, register index width; the number of registers is 2**ADDR_WIDTH = 16.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_hold  in  1  when high, both ready outputs are forced low (no grants).
- req0_valid  in  1  ALU writeback request.
- req0_reg  in  ADDR_WIDTH  ALU destination register.
- req0_data  in  DATA_WIDTH  ALU result.
- req0_ready  out  1  ALU request granted this cycle.
- req1_valid, req1_reg, req1_data, req1_ready: same as requester 0, for the load unit.
- reserve_valid  in  1  decode marks a destination register as pending.
- reserve_reg  in  ADDR_WIDTH  register to mark.
- a_select  in  ADDR_WIDTH  register being read on port A.
- b_select  in  ADDR_WIDTH  register being read on port B.
- a_busy  out  1  combinational: busy[a_select].
- b_busy  out  1  combinational: busy[b_select].
- busy  out  16  scoreboard; bit i = 1 means register i has a pending write.
- port_c  out  DATA_WIDTH  registered write data to the register file.
- decoder_control  out  ADDR_WIDTH  registered write address.
- load_enable  out  1  registered write strobe.
- reserve_error  out  1  sticky flag: a register was reserved while already busy.

Behaviour:
- Reset (asynchronous, reset_n low): port_c=0, decoder_control=0, load_enable=0, busy=0, reserve_error=0, round-robin pointer=0 (requester 0 preferred).
- Arbitration (combinational):
  - wb_hold high: both ready outputs = 0.
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester indicated by the pointer gets ready=1; the other gets 0.
  - A requester never sees ready=1 while its valid is low.
- Handshake: valid & ready at a rising edge is a transfer. A requester that is not granted holds its valid, reg and data stable until it is granted.
- Pointer update: after a grant made while both requesters were valid, the pointer moves to the other requester. Single-requester grants leave the pointer unchanged.
- Write-port latency:
  - The transfer edge loads port_c, decoder_control and load_enable=1.
  - The register file commits the write on the following edge.
  - load_enable returns to 0 on the next edge with no transfer.
  - Back-to-back transfers keep load_enable high, with new address and data every cycle.
  - When load_enable drops to 0, port_c and decoder_control hold their last values.
- Scoreboard:
  - Set: at an edge with reserve_valid=1, busy[reserve_reg] is set.
  - Clear: at an edge with load_enable=1, busy[decoder_control] is cleared. This is the same edge on which the register file writes.
  - Set and clear of the same register at the same edge: set wins.
  - Reserving a register that is already busy: the bit stays 1 and reserve_error is set; it stays set until reset.
  - Writing a register that is not busy is legal and leaves busy unchanged.
- Register 0 has no special treatment; all 16 registers are writable.
- Reset asserted mid-transfer: the output registers clear immediately, and any in-flight write is dropped.

Test Plan:
- Reset, then req0 alone with reg=5, data=0x2A -> req0_ready=1 in the same cycle; next cycle load_enable=1, decoder_control=5, port_c=0x2A; the cycle after, load_enable=0.
- req0 and req1 both valid for 4 cycles (regs 1/2, data 0x11/0x22) -> grants in the order req0, req1, req0, req1; load_enable stays high for 4 consecutive cycles with matching address and data.
- Reserve reg 10, then req1 writes 50 to reg 10 -> busy[10]=1, and a_busy=1 with a_select=10, until the edge where load_enable=1 with decoder_control=10; afterwards busy[10]=0.
- Reserve reg 3 on the same edge that load_enable clears reg 3 -> busy[3]=1 afterwards. A second reserve of reg 3 -> reserve_error=1, and it stays 1.
- wb_hold=1 with both requesters valid for 3 cycles -> req0_ready and req1_ready stay 0 and load_enable stays 0; on release, req0 is granted first (pointer=0).
- Drive reset_n low during a back-to-back write burst -> load_enable, port_c, busy and reserve_error are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_file_write_controller_if.sv
// Writeback request bus between the two requesters (ALU = 0, load unit = 1)
// and the register-file write controller.
interface register_file_write_controller_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_reg;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_reg;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/register_file_write_controller.sv
// Round-robin owner of the register file write port, with a pending-write
// scoreboard for read-after-write hazard detection in decode.
module register_file_write_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wb_hold,
  register_file_write_controller_if.slave wb,
  input  logic                         reserve_valid,
  input  logic [ADDR_WIDTH-1:0]        reserve_reg,
  input  logic [ADDR_WIDTH-1:0]        a_select,
  input  logic [ADDR_WIDTH-1:0]        b_select,
  output logic                         a_busy,
  output logic                         b_busy,
  output logic [(2**ADDR_WIDTH)-1:0]   busy,
  output logic [DATA_WIDTH-1:0]        port_c,
  output logic [ADDR_WIDTH-1:0]        decoder_control,
  output logic                         load_enable,
  output logic                         reserve_error
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic                  r_ptr;
  logic                  w_both;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_wr_reg;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [NumRegs-1:0]    w_busy_clr;
  logic [NumRegs-1:0]    w_busy_d;
  logic                  w_conflict;

  assign w_both   = wb.req0_valid & wb.req1_valid;
  assign w_grant0 = ~wb_hold & wb.req0_valid & (~wb.req1_valid | ~r_ptr);
  assign w_grant1 = ~wb_hold & wb.req1_valid & (~wb.req0_valid | r_ptr);
  assign w_xfer   = w_grant0 | w_grant1;

  assign wb.req0_ready = w_grant0;
  assign wb.req1_ready = w_grant1;

  assign w_wr_reg  = w_grant1 ? wb.req1_reg  : wb.req0_reg;
  assign w_wr_data = w_grant1 ? wb.req1_data : wb.req0_data;

  assign a_busy = busy[a_select];
  assign b_busy = busy[b_select];

  // The commit clears first, so a reservation landing on the clearing edge is
  // a fresh reservation rather than a double booking; set then wins.
  always_comb begin
    w_busy_clr = busy;
    if (load_enable) begin
      w_busy_clr[decoder_control] = 1'b0;
    end
    w_busy_d = w_busy_clr;
    if (reserve_valid) begin
      w_busy_d[reserve_reg] = 1'b1;
    end
    w_conflict = reserve_valid & w_busy_clr[reserve_reg];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr           <= 1'b0;
      port_c          <= '0;
      decoder_control <= '0;
      load_enable     <= 1'b0;
      busy            <= '0;
      reserve_error   <= 1'b0;
    end else begin
      if (w_xfer && w_both) begin
        r_ptr <= w_grant0;
      end
      load_enable <= w_xfer;
      if (w_xfer) begin
        port_c          <= w_wr_data;
        decoder_control <= w_wr_reg;
      end
      busy <= w_busy_d;
      if (w_conflict) begin
        reserve_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_file_write_controller.sv
// Bench for register_file_write_controller: directed scenarios followed by
// randomized traffic, all compared against a behavioural scoreboard model.
module tb_register_file_write_controller;

  logic        clk;
  logic        reset_n;
  logic        hold;
  logic        res_v;
  logic [3:0]  res_r;
  logic [3:0]  a_sel;
  logic [3:0]  b_sel;
  logic        a_busy;
  logic        b_busy;
  logic [15:0] busy;
  logic [31:0] port_c;
  logic [3:0]  decoder_control;
  logic        load_enable;
  logic        reserve_error;

  logic        rv[2];
  logic [3:0]  rreg[2];
  logic [31:0] rdata[2];
  bit          sticky;

  int n_chk;
  int n_err;

  // Reference model state
  int          m_pref;
  bit          m_le;
  int          m_dc;
  logic [31:0] m_pc;
  bit          m_busy[16];
  bit          m_err;

  logic [1:0]  last_rdy;
  logic        last_abusy;

  register_file_write_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) wb_if ();

  assign wb_if.req0_valid = rv[0];
  assign wb_if.req0_reg   = rreg[0];
  assign wb_if.req0_data  = rdata[0];
  assign wb_if.req1_valid = rv[1];
  assign wb_if.req1_reg   = rreg[1];
  assign wb_if.req1_data  = rdata[1];

  register_file_write_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wb_hold         (hold),
    .wb              (wb_if),
    .reserve_valid   (res_v),
    .reserve_reg     (res_r),
    .a_select        (a_sel),
    .b_select        (b_sel),
    .a_busy          (a_busy),
    .b_busy          (b_busy),
    .busy            (busy),
    .port_c          (port_c),
    .decoder_control (decoder_control),
    .load_enable     (load_enable),
    .reserve_error   (reserve_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_pref = 0;
    m_le   = 0;
    m_dc   = 0;
    m_pc   = '0;
    m_err  = 0;
    for (int i = 0; i < 16; i++) m_busy[i] = 0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] r, input logic [31:0] d);
    rv[i]    = v;
    rreg[i]  = r;
    rdata[i] = d;
  endtask

  // Called one time unit after a rising edge; returns one unit after the next.
  task automatic tick();
    int g;
    bit clr_v;
    int clr_r;
    #4;
    g = -1;
    if (!hold) begin
      if (rv[0] && rv[1]) g = m_pref;
      else if (rv[0])     g = 0;
      else if (rv[1])     g = 1;
    end
    last_rdy   = {wb_if.req1_ready, wb_if.req0_ready};
    last_abusy = a_busy;
    chk("ready0", wb_if.req0_ready, g == 0);
    chk("ready1", wb_if.req1_ready, g == 1);
    chk("a_busy", a_busy, m_busy[a_sel]);
    chk("b_busy", b_busy, m_busy[b_sel]);
    @(posedge clk);
    if (rv[0] && rv[1] && g >= 0) m_pref = 1 - g;
    clr_v = m_le;
    clr_r = m_dc;
    if (g >= 0) begin
      m_le = 1;
      m_dc = rreg[g];
      m_pc = rdata[g];
    end else begin
      m_le = 0;
    end
    if (clr_v) m_busy[clr_r] = 0;
    if (res_v) begin
      if (m_busy[res_r]) m_err = 1;
      m_busy[res_r] = 1;
    end
    #1;
    chk("load_enable", load_enable, m_le);
    chk("decoder_control", decoder_control, m_dc);
    chk("port_c", port_c, m_pc);
    chk("busy", busy, model_busy());
    chk("reserve_error", reserve_error, m_err);
    if (g >= 0 && !sticky) rv[g] = 1'b0;
    res_v = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    sticky  = 0;
    reset_n = 1'b0;
    hold    = 1'b0;
    res_v   = 1'b0;
    res_r   = '0;
    a_sel   = '0;
    b_sel   = '0;
    set_req(0, 1'b0, 4'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0);
    model_reset();
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_le", load_enable, 1'b0);
    chk("rst_pc", port_c, 32'd0);
    chk("rst_dc", decoder_control, 4'd0);
    chk("rst_busy", busy, 16'd0);
    chk("rst_err", reserve_error, 1'b0);

    // Single ALU write
    set_req(0, 1'b1, 4'd5, 32'h2A);
    tick();
    chk("t1_rdy", last_rdy, 2'b01);
    chk("t1_le", load_enable, 1'b1);
    chk("t1_dc", decoder_control, 4'd5);
    chk("t1_pc", port_c, 32'h2A);
    tick();
    chk("t1_le_drop", load_enable, 1'b0);
    chk("t1_pc_hold", port_c, 32'h2A);

    // Both requesters contend for four cycles
    sticky = 1;
    set_req(0, 1'b1, 4'd1, 32'h11);
    set_req(1, 1'b1, 4'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_grant", last_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_le", load_enable, 1'b1);
      chk("t2_dc", decoder_control, (i % 2 == 0) ? 4'd1 : 4'd2);
      chk("t2_pc", port_c, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    sticky = 0;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    tick();

    // Reserve reg 10, then the load unit writes it
    res_v = 1'b1;
    res_r = 4'd10;
    a_sel = 4'd10;
    tick();
    chk("t3_busy_set", busy[10], 1'b1);
    set_req(1, 1'b1, 4'd10, 32'd50);
    tick();
    chk("t3_abusy", last_abusy, 1'b1);
    chk("t3_still_busy", busy[10], 1'b1);
    tick();
    chk("t3_abusy_pre_clr", last_abusy, 1'b1);
    chk("t3_busy_clr", busy[10], 1'b0);

    // Reserve reg 3 on the very edge its write commits
    res_v = 1'b1;
    res_r = 4'd3;
    tick();
    set_req(0, 1'b1, 4'd3, 32'h33);
    tick();
    res_v = 1'b1;
    res_r = 4'd3;
    tick();
    chk("t4_busy_kept", busy[3], 1'b1);
    chk("t4_no_err", reserve_error, 1'b0);
    res_v = 1'b1;
    res_r = 4'd3;
    tick();
    chk("t4_err", reserve_error, 1'b1);
    tick();
    tick();
    chk("t4_err_sticky", reserve_error, 1'b1);

    // Hold both requesters off
    hold = 1'b1;
    set_req(0, 1'b1, 4'd4, 32'h44);
    set_req(1, 1'b1, 4'd6, 32'h66);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_grant", last_rdy, 2'b00);
      chk("t5_le", load_enable, 1'b0);
    end
    hold = 1'b0;
    tick();
    chk("t5_first", last_rdy, 2'b01);
    tick();
    chk("t5_second", last_rdy, 2'b10);

    // Reset during a back-to-back burst
    sticky = 1;
    set_req(0, 1'b1, 4'd7, 32'hA5A5_0007);
    set_req(1, 1'b1, 4'd8, 32'h5A5A_0008);
    res_v = 1'b1;
    res_r = 4'd12;
    tick();
    tick();
    chk("t6_pre_le", load_enable, 1'b1);
    chk("t6_pre_busy", busy[12], 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_le", load_enable, 1'b0);
    chk("t6_pc", port_c, 32'd0);
    chk("t6_busy", busy, 16'd0);
    chk("t6_err", reserve_error, 1'b0);
    sticky = 0;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    model_reset();
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      hold = ($urandom_range(7) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && $urandom_range(1) == 1) begin
          set_req(i, 1'b1, 4'($urandom_range(15)), $urandom);
        end
      end
      res_v = ($urandom_range(3) == 0);
      res_r = 4'($urandom_range(15));
      a_sel = 4'($urandom_range(15));
      b_sel = 4'($urandom_range(15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
